lcd_pixel_scanout: RTL and testbench

- Sits directly downstream of fifo_32. Pops 32-bit pixel words from the FIFO read port.
- Generates parallel-RGB LCD timing: hsync, vsync, data-enable and 24-bit RGB.
- Runs entirely in the FIFO read/pixel clock domain.
- Guarantees a read is never issued to an empty FIFO. Flags underflow when a displayed pixel was unavailable.

---
 rtl/lcd_pixel_scanout.sv | 166 ++++++++++++++++
 tb/tb_lcd_pixel_scanout.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_scanout.sv
// lcd_pixel_scanout: pops 32-bit pixel words from an upstream FIFO and drives
// parallel-RGB LCD timing (hsync, vsync, data enable, 24-bit RGB).
// Ports:
//   i_clock          pixel clock, also the FIFO read clock
//   i_nReset         asynchronous active-low reset
//   i_enable         start/continue scanning frames (frame completes on drop)
//   i_clearUnderflow single-cycle clear of o_underflow
//   i_fifoData       FIFO read data, valid the cycle after o_fifoRead
//   i_fifoEmpty      FIFO empty flag
//   o_fifoRead       FIFO pop strobe (combinational, never while empty)
//   o_hsync/o_vsync  active-low syncs
//   o_de, o_rgb      data enable and pixel data
//   o_underflow      sticky: an active pixel found the FIFO empty
//   o_frameStart     one-cycle pulse with the first o_de of each frame
module lcd_pixel_scanout #(
   parameter int unsigned H_ACTIVE = 800,
   parameter int unsigned H_FRONT  = 40,
   parameter int unsigned H_SYNC   = 48,
   parameter int unsigned H_BACK   = 88,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FRONT  = 13,
   parameter int unsigned V_SYNC   = 3,
   parameter int unsigned V_BACK   = 32
) (
   input  logic        i_clock,
   input  logic        i_nReset,
   input  logic        i_enable,
   input  logic        i_clearUnderflow,
   input  logic [31:0] i_fifoData,
   input  logic        i_fifoEmpty,
   output logic        o_fifoRead,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic [23:0] o_rgb,
   output logic        o_underflow,
   output logic        o_frameStart
);

   localparam int unsigned H_TOTAL      = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL      = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned H_W          = $clog2(H_TOTAL);
   localparam int unsigned V_W          = $clog2(V_TOTAL);
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FRONT;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FRONT;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_FILL = 2'd1,
      S_RUN       = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_nextState;
   logic [H_W-1:0] r_hCount;
   logic [V_W-1:0] r_vCount;
   logic           w_hLast;
   logic           w_vLast;
   logic           w_run;
   logic           w_pixelActive;
   logic           w_hsyncRegion;
   logic           w_vsyncRegion;
   logic           w_frameFirst;
   logic           w_unusedTop;

   // Stage 1 pipeline
   logic           r_s1Active;
   logic           r_s1Taken;
   logic           r_s1Hsync;
   logic           r_s1Vsync;
   logic           r_s1FrameStart;

   // Upper byte of the FIFO word carries no pixel data
   assign w_unusedTop = ^i_fifoData[31:24];

   assign w_hLast = (r_hCount == H_W'(H_TOTAL - 1));
   assign w_vLast = (r_vCount == V_W'(V_TOTAL - 1));
   assign w_run   = (r_state == S_RUN);

   // Stage 0: position decodes straight from the counters
   assign w_pixelActive = w_run && (r_hCount < H_W'(H_ACTIVE)) && (r_vCount < V_W'(V_ACTIVE));
   assign w_hsyncRegion = w_run && (r_hCount >= H_W'(H_SYNC_START)) && (r_hCount < H_W'(H_SYNC_END));
   assign w_vsyncRegion = w_run && (r_vCount >= V_W'(V_SYNC_START)) && (r_vCount < V_W'(V_SYNC_END));
   assign w_frameFirst  = w_run && (r_hCount == '0) && (r_vCount == '0);
   assign o_fifoRead    = w_pixelActive && !i_fifoEmpty;

   // FSM state register
   always_ff @(posedge i_clock or negedge i_nReset) begin
      if (!i_nReset) r_state <= S_IDLE;
      else           r_state <= w_nextState;
   end

   // FSM next state; once running, a frame always completes
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_enable) w_nextState = S_WAIT_FILL;
         end
         S_WAIT_FILL: begin
            if (!i_enable)        w_nextState = S_IDLE;
            else if (!i_fifoEmpty) w_nextState = S_RUN;
         end
         S_RUN: begin
            if (!i_enable && w_hLast && w_vLast) w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // Raster counters: free-run in RUN, held at the origin otherwise
   always_ff @(posedge i_clock or negedge i_nReset) begin
      if (!i_nReset) begin
         r_hCount <= '0;
         r_vCount <= '0;
      end else if (!w_run) begin
         r_hCount <= '0;
         r_vCount <= '0;
      end else if (w_hLast) begin
         r_hCount <= '0;
         r_vCount <= w_vLast ? '0 : r_vCount + V_W'(1);
      end else begin
         r_hCount <= r_hCount + H_W'(1);
      end
   end

   // Stage 1: lines up with the FIFO read data
   always_ff @(posedge i_clock or negedge i_nReset) begin
      if (!i_nReset) begin
         r_s1Active     <= 1'b0;
         r_s1Taken      <= 1'b0;
         r_s1Hsync      <= 1'b0;
         r_s1Vsync      <= 1'b0;
         r_s1FrameStart <= 1'b0;
      end else begin
         r_s1Active     <= w_pixelActive;
         r_s1Taken      <= o_fifoRead;
         r_s1Hsync      <= w_hsyncRegion;
         r_s1Vsync      <= w_vsyncRegion;
         r_s1FrameStart <= w_frameFirst;
      end
   end

   // Stage 2: registered pins; a missed pixel shows black and sets underflow
   always_ff @(posedge i_clock or negedge i_nReset) begin
      if (!i_nReset) begin
         o_de         <= 1'b0;
         o_rgb        <= '0;
         o_hsync      <= 1'b1;
         o_vsync      <= 1'b1;
         o_frameStart <= 1'b0;
         o_underflow  <= 1'b0;
      end else begin
         o_de         <= r_s1Active;
         o_rgb        <= r_s1Taken ? i_fifoData[23:0] : 24'h000000;
         o_hsync      <= !r_s1Hsync;
         o_vsync      <= !r_s1Vsync;
         o_frameStart <= r_s1FrameStart;
         if (r_s1Active && !r_s1Taken) o_underflow <= 1'b1;
         else if (i_clearUnderflow)     o_underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lcd_pixel_scanout.sv
// Directed bench for lcd_pixel_scanout on a 48-clock, 12-pixel test raster.
module tb_lcd_pixel_scanout;

   logic        clk = 1'b0;
   logic        i_nReset = 1'b0;
   logic        i_enable = 1'b0;
   logic        i_clearUnderflow = 1'b0;
   logic [31:0] i_fifoData;
   logic        i_fifoEmpty;
   logic        o_fifoRead;
   logic        o_hsync;
   logic        o_vsync;
   logic        o_de;
   logic [23:0] o_rgb;
   logic        o_underflow;
   logic        o_frameStart;

   always #5 clk = ~clk;

   lcd_pixel_scanout #(
      .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
   ) dut (
      .i_clock         (clk),
      .i_nReset        (i_nReset),
      .i_enable        (i_enable),
      .i_clearUnderflow(i_clearUnderflow),
      .i_fifoData      (i_fifoData),
      .i_fifoEmpty     (i_fifoEmpty),
      .o_fifoRead      (o_fifoRead),
      .o_hsync         (o_hsync),
      .o_vsync         (o_vsync),
      .o_de            (o_de),
      .o_rgb           (o_rgb),
      .o_underflow     (o_underflow),
      .o_frameStart    (o_frameStart)
   );

   // FIFO model: written by the stimulus, popped here; data valid after the pop
   logic [31:0] mem [0:63];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          rd_empty_viol = 0;
   logic [31:0] fifo_q = 32'h0;

   assign i_fifoEmpty = (wr_ptr == rd_ptr);
   assign i_fifoData  = fifo_q;

   always @(posedge clk) begin
      if (o_fifoRead) begin
         if (wr_ptr == rd_ptr) rd_empty_viol <= rd_empty_viol + 1;
         else begin
            fifo_q <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
         end
      end
   end

   int vectors = 0;
   int miscompares = 0;

   // Per-window observation statistics
   int          cyc, de_cnt, fs_cnt, fs_first_ok, hs_fall, vs_low;
   int          sync_de_viol, de_bursts, hs_after_de_ok, last_de_rise;
   logic        prev_de, prev_hs;
   logic [23:0] rgb_log [0:15];
   int          pop_base;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      cyc = 0; de_cnt = 0; fs_cnt = 0; fs_first_ok = 0; hs_fall = 0; vs_low = 0;
      sync_de_viol = 0; de_bursts = 0; hs_after_de_ok = 0; last_de_rise = -100;
      prev_de = 1'b0; prev_hs = 1'b1;
      for (int i = 0; i < 16; i++) rgb_log[i] = 24'h0;
      pop_base = rd_ptr;
   endtask

   task automatic sample();
      cyc++;
      if (o_de) begin
         if (de_cnt < 16) rgb_log[de_cnt] = o_rgb;
         if (o_frameStart && de_cnt == 0) fs_first_ok++;
         de_cnt++;
         if (!prev_de) begin
            de_bursts++;
            last_de_rise = cyc;
         end
      end
      if (o_frameStart) fs_cnt++;
      if (!o_hsync && prev_hs) begin
         hs_fall++;
         if (cyc - last_de_rise == 5) hs_after_de_ok++;
      end
      if (!o_vsync) vs_low++;
      if (o_de && (!o_hsync || !o_vsync)) sync_de_viol++;
      prev_de = o_de;
      prev_hs = o_hsync;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sample();
      end
   endtask

   task automatic push(input logic [31:0] w);
      mem[wr_ptr % 64] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      i_nReset = 1'b0;
      @(negedge clk);
      i_nReset = 1'b1;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      chk("rst hsync",  32'(o_hsync), 32'd1);
      chk("rst vsync",  32'(o_vsync), 32'd1);
      chk("rst de",     32'(o_de), 32'd0);
      chk("rst rgb",    32'(o_rgb), 32'd0);
      chk("rst read",   32'(o_fifoRead), 32'd0);
      chk("rst uflow",  32'(o_underflow), 32'd0);
      chk("rst fstart", 32'(o_frameStart), 32'd0);

      // Full frame from 12 prefilled words, upper byte must be ignored
      for (int k = 1; k <= 12; k++) push({8'hA5, 24'(k)});
      pulse_reset();
      clear_stats();
      i_enable = 1'b1;
      step(3);
      i_enable = 1'b0;
      step(60);
      chk("t1 de count", 32'(de_cnt), 32'd12);
      for (int k = 0; k < 12; k++) chk($sformatf("t1 rgb[%0d]", k), 32'(rgb_log[k]), 32'(k + 1));
      chk("t1 bursts", 32'(de_bursts), 32'd3);
      chk("t1 fstart count", 32'(fs_cnt), 32'd1);
      chk("t1 fstart on first de", 32'(fs_first_ok), 32'd1);
      chk("t1 underflow", 32'(o_underflow), 32'd0);
      chk("t1 pops", 32'(rd_ptr - pop_base), 32'd12);
      chk("t1 hsync pulses", 32'(hs_fall), 32'd6);
      chk("t1 hsync 5 after line de", 32'(hs_after_de_ok), 32'd3);
      chk("t1 vsync low clocks", 32'(vs_low), 32'd8);
      chk("t1 de during sync", 32'(sync_de_viol), 32'd0);

      // Only 6 words: second half of the frame underflows to black
      for (int k = 1; k <= 6; k++) push({8'h5A, 24'(100 + k)});
      pulse_reset();
      clear_stats();
      i_enable = 1'b1;
      step(3);
      i_enable = 1'b0;
      step(60);
      chk("t3 de count", 32'(de_cnt), 32'd12);
      for (int k = 0; k < 12; k++)
         chk($sformatf("t3 rgb[%0d]", k), 32'(rgb_log[k]), (k < 6) ? 32'(101 + k) : 32'd0);
      chk("t3 pops", 32'(rd_ptr - pop_base), 32'd6);
      chk("t3 read while empty", 32'(rd_empty_viol), 32'd0);
      chk("t3 underflow set", 32'(o_underflow), 32'd1);
      step(2);
      chk("t3 underflow sticky", 32'(o_underflow), 32'd1);
      i_clearUnderflow = 1'b1;
      step(1);
      i_clearUnderflow = 1'b0;
      chk("t3 underflow cleared", 32'(o_underflow), 32'd0);

      // Enable with an empty FIFO: hold in WAIT_FILL, then one word starts the frame
      pulse_reset();
      clear_stats();
      i_enable = 1'b1;
      step(20);
      chk("t4 no de", 32'(de_cnt), 32'd0);
      chk("t4 no hsync", 32'(hs_fall), 32'd0);
      chk("t4 no vsync", 32'(vs_low), 32'd0);
      chk("t4 no pops", 32'(rd_ptr - pop_base), 32'd0);
      clear_stats();
      push(32'hFF123456);
      step(1);
      chk("t4 de +1", 32'(o_de), 32'd0);
      step(1);
      chk("t4 de +2", 32'(o_de), 32'd0);
      step(1);
      chk("t4 de +3", 32'(o_de), 32'd1);
      chk("t4 rgb +3", 32'(o_rgb), 32'h00123456);
      chk("t4 fstart +3", 32'(o_frameStart), 32'd1);
      i_enable = 1'b0;
      step(60);
      chk("t4 de count", 32'(de_cnt), 32'd12);
      chk("t4 underflow", 32'(o_underflow), 32'd1);
      chk("t4 read while empty", 32'(rd_empty_viol), 32'd0);

      // Drop enable mid-frame with 24 words queued
      for (int k = 1; k <= 24; k++) push(32'(200 + k));
      pulse_reset();
      clear_stats();
      i_enable = 1'b1;
      step(18);
      i_enable = 1'b0;
      step(60);
      chk("t5 de count", 32'(de_cnt), 32'd12);
      chk("t5 rgb first", 32'(rgb_log[0]), 32'd201);
      chk("t5 rgb last", 32'(rgb_log[11]), 32'd212);
      chk("t5 pops", 32'(rd_ptr - pop_base), 32'd12);
      chk("t5 remaining", 32'(wr_ptr - rd_ptr), 32'd12);
      chk("t5 fstart count", 32'(fs_cnt), 32'd1);
      chk("t5 underflow", 32'(o_underflow), 32'd0);

      // Reset asserted while pixel 5 is on the pins
      clear_stats();
      i_enable = 1'b1;
      for (int i = 0; i < 60 && de_cnt < 5; i++) step(1);
      chk("t6 reach pixel 5", 32'(de_cnt), 32'd5);
      chk("t6 pixel 5 rgb", 32'(rgb_log[4]), 32'd217);
      #2 i_nReset = 1'b0;
      #1;
      chk("t6 async de", 32'(o_de), 32'd0);
      chk("t6 async rgb", 32'(o_rgb), 32'd0);
      chk("t6 async hsync", 32'(o_hsync), 32'd1);
      chk("t6 async vsync", 32'(o_vsync), 32'd1);
      chk("t6 async read", 32'(o_fifoRead), 32'd0);
      chk("t6 async fstart", 32'(o_frameStart), 32'd0);
      @(negedge clk);
      i_nReset = 1'b1;
      clear_stats();
      for (int i = 0; i < 60 && de_cnt < 1; i++) step(1);
      chk("t6 restart de", 32'(de_cnt), 32'd1);
      chk("t6 restart fstart", 32'(fs_first_ok), 32'd1);
      chk("t6 restart rgb", 32'(rgb_log[0]), 32'd219);
      i_enable = 1'b0;
      step(60);
      chk("t6 idle de", 32'(o_de), 32'd0);
      chk("end read while empty", 32'(rd_empty_viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
